// File: rtl/matmul_pkg.sv
// Shared types and default constants for the matrix-multiply sequencer.
// The saturating datapath is selected with the MATMUL_SAT_EN macro.
package matmul_pkg;

    localparam int DEF_N  = 3;
    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

    localparam logic [DEF_DW-1:0] SAT_LIMIT = {DEF_DW{1'b1}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WR_C = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage

// File: rtl/matmul_mac.sv
// Multiply-accumulate unit: holds the A operand and the running dot-product sum.
// MATMUL_SAT_EN selects clamping at all-ones; otherwise results wrap modulo 2^DW.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          load_a_i,
    input  logic          accum_i,
    input  logic [DW-1:0] rdata_i,
    output logic [DW-1:0] acc_o
);

    localparam int PW = 2 * DW;

    logic [DW-1:0] a_q;
    logic [DW-1:0] a_d;
    logic [DW-1:0] acc_q;
    logic [DW-1:0] acc_d;
    logic [DW-1:0] sum_s;
    logic [PW-1:0] prod_s;

    assign prod_s = PW'(a_q) * PW'(rdata_i);

`ifdef MATMUL_SAT_EN
    localparam logic [DW-1:0] LIMIT = (DW <= DEF_DW) ? DW'(SAT_LIMIT) : {DW{1'b1}};

    logic [DW-1:0] prod_sat_s;
    logic [DW:0]   wide_sum_s;

    // Clamp the product first, then clamp the sum using its carry-out.
    assign prod_sat_s = (|prod_s[PW-1:DW]) ? LIMIT : prod_s[DW-1:0];
    assign wide_sum_s = {1'b0, acc_q} + {1'b0, prod_sat_s};
    assign sum_s      = wide_sum_s[DW] ? LIMIT : wide_sum_s[DW-1:0];
`else
    logic unused_prod_hi_s;

    assign unused_prod_hi_s = ^prod_s[PW-1:DW];
    assign sum_s            = acc_q + prod_s[DW-1:0];
`endif

    // Next-state selection for operand and accumulator registers.
    always_comb begin
        a_d   = a_q;
        acc_d = acc_q;
        if (load_a_i) begin
            a_d = rdata_i;
        end else begin
            a_d = a_q;
        end
        if (clr_i) begin
            acc_d = {DW{1'b0}};
        end else if (accum_i) begin
            acc_d = sum_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Operand and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= {DW{1'b0}};
            acc_q <= {DW{1'b0}};
        end else begin
            a_q   <= a_d;
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/matmul_sequencer.sv
// Sequencer computing C = A x B over a shared data memory, with CPU pass-through when idle.
// Optional saturating arithmetic via MATMUL_SAT_EN (handled inside matmul_mac).
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_a,
    input  logic [AW-1:0] base_b,
    input  logic [AW-1:0] base_c,
    output logic          busy,
    output logic          done,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    input  logic          cpu_re,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [AW-1:0] N_A  = AW'(N);

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] i_q;
    logic [CW-1:0] i_d;
    logic [CW-1:0] j_q;
    logic [CW-1:0] j_d;
    logic [CW-1:0] k_q;
    logic [CW-1:0] k_d;
    logic [AW-1:0] ba_q;
    logic [AW-1:0] ba_d;
    logic [AW-1:0] bb_q;
    logic [AW-1:0] bb_d;
    logic [AW-1:0] bc_q;
    logic [AW-1:0] bc_d;
    logic          busy_q;
    logic          done_q;

    logic          clr_s;
    logic          load_a_s;
    logic          accum_s;
    logic [DW-1:0] acc_s;
    logic [AW-1:0] a_addr_s;
    logic [AW-1:0] b_addr_s;
    logic [AW-1:0] c_addr_s;

    // Row-major element addresses; the AW-bit result wraps naturally.
    assign a_addr_s = ba_q + AW'(i_q) * N_A + AW'(k_q);
    assign b_addr_s = bb_q + AW'(k_q) * N_A + AW'(j_q);
    assign c_addr_s = bc_q + AW'(i_q) * N_A + AW'(j_q);

    matmul_mac #(
        .DW (DW)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (clr_s),
        .load_a_i (load_a_s),
        .accum_i  (accum_s),
        .rdata_i  (mem_rdata),
        .acc_o    (acc_s)
    );

    // Next-state, counter and memory-port mux logic.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        ba_d      = ba_q;
        bb_d      = bb_q;
        bc_d      = bc_q;
        clr_s     = 1'b0;
        load_a_s  = 1'b0;
        accum_s   = 1'b0;
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        cpu_rdata = {DW{1'b0}};
        case (state_q)
            IDLE: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_we;
                mem_re    = cpu_re;
                cpu_rdata = mem_rdata;
                if (start) begin
                    ba_d    = base_a;
                    bb_d    = base_b;
                    bc_d    = base_c;
                    i_d     = ZERO;
                    j_d     = ZERO;
                    k_d     = ZERO;
                    clr_s   = 1'b1;
                    state_d = RD_A;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_A: begin
                mem_re   = 1'b1;
                mem_addr = a_addr_s;
                load_a_s = 1'b1;
                state_d  = RD_B;
            end
            RD_B: begin
                mem_re   = 1'b1;
                mem_addr = b_addr_s;
                accum_s  = 1'b1;
                if (k_q == LAST) begin
                    state_d = WR_C;
                end else begin
                    k_d     = k_q + ONE;
                    state_d = RD_A;
                end
            end
            WR_C: begin
                mem_we    = 1'b1;
                mem_addr  = c_addr_s;
                mem_wdata = acc_s;
                clr_s     = 1'b1;
                k_d       = ZERO;
                if (j_q == LAST) begin
                    j_d = ZERO;
                    if (i_q == LAST) begin
                        i_d     = ZERO;
                        state_d = DONE;
                    end else begin
                        i_d     = i_q + ONE;
                        state_d = RD_A;
                    end
                end else begin
                    j_d     = j_q + ONE;
                    state_d = RD_A;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, latched bases and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= ZERO;
            j_q     <= ZERO;
            k_q     <= ZERO;
            ba_q    <= {AW{1'b0}};
            bb_q    <= {AW{1'b0}};
            bc_q    <= {AW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            ba_q    <= ba_d;
            bb_q    <= bb_d;
            bc_q    <= bc_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign cpu_stall = busy_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: table-driven CPU pass-through vectors,
// directed multi-cycle scenarios and randomized matrices against a plain-arithmetic model.
module tb_matmul_sequencer;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int NN = N * N;
    localparam int DONE_CYC = NN * (2 * N + 1) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_a = 16'h0000;
    logic [AW-1:0] base_b = 16'h0000;
    logic [AW-1:0] base_c = 16'h0000;
    logic          busy;
    logic          done;
    logic [AW-1:0] cpu_addr = 16'h0000;
    logic [DW-1:0] cpu_wdata = 16'h0000;
    logic          cpu_we = 1'b0;
    logic          cpu_re = 1'b0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;

    logic [15:0] mem [0:65535];
    logic [15:0] exp_c [0:NN-1];

    int vecs = 0;
    int errs = 0;

    matmul_sequencer #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_a    (base_a),
        .base_b    (base_b),
        .base_c    (base_c),
        .busy      (busy),
        .done      (done),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: C[r][c] = sum over k of A[r][k]*B[k][c], clamped or wrapped per build.
    function automatic logic [15:0] ref_elem(input logic [15:0] ba, input logic [15:0] bb,
                                             input int r, input int c);
        longint acc;
        longint p;
        acc = 0;
        for (int k = 0; k < N; k++) begin
            p = longint'(mem[16'(ba + r * N + k)]) * longint'(mem[16'(bb + k * N + c)]);
`ifdef MATMUL_SAT_EN
            if (p > 65535) p = 65535;
            acc = acc + p;
            if (acc > 65535) acc = 65535;
`else
            acc = (acc + p) % 65536;
`endif
        end
        return acc[15:0];
    endfunction

    task automatic prep_expect(input logic [15:0] ba, input logic [15:0] bb);
        for (int e = 0; e < NN; e++) exp_c[e] = ref_elem(ba, bb, e / N, e % N);
    endtask

    task automatic fill_c(input logic [15:0] bc);
        for (int e = 0; e < NN; e++) mem[16'(bc + e)] = 16'hDEAD;
    endtask

    task automatic check_c(input string name, input logic [15:0] bc, input int nwritten);
        for (int e = 0; e < NN; e++) begin
            if (e < nwritten) check(name, 32'(mem[16'(bc + e)]), 32'(exp_c[e]));
            else              check(name, 32'(mem[16'(bc + e)]), 32'h0000DEAD);
        end
    endtask

    task automatic run_op(input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bc,
                          input int restart_at, input int reset_at, input bit cpu_hold);
        int  n_done;
        int  late_we;
        bit  exp_busy;
        n_done  = 0;
        late_we = 0;
        @(negedge clk);
        base_a = ba;
        base_b = bb;
        base_c = bc;
        start  = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1) begin
                base_a = ~ba;
                base_b = ~bb;
                base_c = ~bc;
                if (cpu_hold) begin
                    cpu_addr  = 16'd50;
                    cpu_wdata = 16'd7;
                    cpu_we    = 1'b1;
                end
            end
            if (reset_at != 0 && c == reset_at) rst_n = 1'b0;
            #1;
            exp_busy = (reset_at == 0 || c < reset_at) && (c <= DONE_CYC);
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_busy && c == DONE_CYC));
            check("cpu_stall", 32'(cpu_stall), 32'(exp_busy));
            if (exp_busy) check("cpu_rdata_busy", 32'(cpu_rdata), 32'h0);
            check("we_re_excl", 32'(mem_we & mem_re), 32'h0);
            if (done) n_done++;
            if (reset_at != 0 && c >= reset_at && mem_we) late_we++;
            if (cpu_hold && c == DONE_CYC) check("cpu_blocked", 32'(mem[50]), 32'h5555);
            if (reset_at != 0 && c == reset_at + 2) rst_n = 1'b1;
            start = (c == restart_at);
        end
        start = 1'b0;
        check("done_count", 32'(n_done), (reset_at != 0) ? 32'd0 : 32'd1);
        if (reset_at != 0) check("late_mem_we", 32'(late_we), 32'd0);
        if (cpu_hold) begin
            check("cpu_released", 32'(mem[50]), 32'd7);
            cpu_we = 1'b0;
        end
    endtask

    typedef struct {
        logic        we;
        logic        re;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t tbl [0:7];
    logic [15:0] exp33 [0:NN-1];
    logic [15:0] sat_c00;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 16'd100,   16'h1234, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 16'd101,   16'hABCD, 16'h0000};
        tbl[2] = '{1'b0, 1'b1, 16'd100,   16'h0000, 16'h1234};
        tbl[3] = '{1'b0, 1'b1, 16'd101,   16'h0000, 16'hABCD};
        tbl[4] = '{1'b0, 1'b1, 16'd102,   16'h0000, 16'h0000};
        tbl[5] = '{1'b1, 1'b0, 16'hFFFF,  16'h0F0F, 16'h0000};
        tbl[6] = '{1'b0, 1'b1, 16'hFFFF,  16'h0000, 16'h0F0F};
        tbl[7] = '{1'b0, 1'b0, 16'd7,     16'h0000, 16'h0000};
        exp33 = '{16'd6, 16'd12, 16'd18, 16'd6, 16'd12, 16'd18, 16'd6, 16'd12, 16'd18};
`ifdef MATMUL_SAT_EN
        sat_c00 = 16'hFFFF;
`else
        sat_c00 = 16'h0000;
`endif

        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_stall", 32'(cpu_stall), 32'h0);
        rst_n = 1'b1;

        // Idle pass-through vectors
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            cpu_we    = tbl[v].we;
            cpu_re    = tbl[v].re;
            cpu_addr  = tbl[v].addr;
            cpu_wdata = tbl[v].wdata;
            #1;
            check("pt_mem_we", 32'(mem_we), 32'(tbl[v].we));
            check("pt_mem_re", 32'(mem_re), 32'(tbl[v].re));
            check("pt_mem_addr", 32'(mem_addr), 32'(tbl[v].addr));
            check("pt_stall", 32'(cpu_stall), 32'h0);
            if (tbl[v].we) check("pt_mem_wdata", 32'(mem_wdata), 32'(tbl[v].wdata));
            if (tbl[v].re) check("pt_cpu_rdata", 32'(cpu_rdata), 32'(tbl[v].exp_rdata));
        end
        @(negedge clk);
        cpu_we = 1'b0;
        cpu_re = 1'b0;

        // Reference 1,2,3 pattern with CPU store held during the operation
        for (int a = 0; a < 18; a++) mem[a] = 16'(a % 3 + 1);
        fill_c(16'd32);
        mem[50] = 16'h5555;
        run_op(16'd0, 16'd9, 16'd32, 0, 0, 1'b1);
        for (int e = 0; e < NN; e++) check("basic_c", 32'(mem[32 + e]), 32'(exp33[e]));

        // Start re-pulsed mid-operation
        fill_c(16'd32);
        prep_expect(16'd0, 16'd9);
        run_op(16'd0, 16'd9, 16'd32, 10, 0, 1'b0);
        check_c("restart_c", 16'd32, NN);

        // Product overflow: clamp or wrap
        for (int a = 0; a < 18; a++) mem[a] = 16'h0000;
        mem[0] = 16'h8000;
        mem[9] = 16'h0002;
        fill_c(16'd32);
        run_op(16'd0, 16'd9, 16'd32, 0, 0, 1'b0);
        check("sat_c00", 32'(mem[32]), 32'(sat_c00));
        for (int e = 1; e < NN; e++) check("sat_rest", 32'(mem[32 + e]), 32'h0);

        // Reset at cycle 20: two elements already written
        for (int a = 0; a < 2 * NN; a++) mem[300 + a] = 16'($urandom_range(0, 300));
        prep_expect(16'd300, 16'd309);
        fill_c(16'd340);
        run_op(16'd300, 16'd309, 16'd340, 0, 20, 1'b0);
        check_c("reset_c", 16'd340, 2);

        // C base wrapping past the top of the address space
        for (int a = 0; a < 2 * NN; a++) mem[100 + a] = 16'($urandom_range(0, 1000));
        prep_expect(16'd100, 16'd106);
        fill_c(16'hFFFC);
        run_op(16'd100, 16'd106, 16'hFFFC, 0, 0, 1'b0);
        check_c("wrap_c", 16'hFFFC, NN);

        // Randomized matrices and bases
        for (int t = 0; t < 4; t++) begin
            logic [15:0] ba;
            ba = 16'($urandom_range(0, 65535));
            for (int e = 0; e < 2 * NN; e++) begin
                if (t % 2 == 1) mem[16'(ba + e)] = 16'($urandom_range(0, 65535));
                else            mem[16'(ba + e)] = 16'($urandom_range(0, 300));
            end
            prep_expect(ba, 16'(ba + NN));
            fill_c(16'(ba + 32));
            run_op(ba, 16'(ba + NN), 16'(ba + 32), 0, 0, 1'b0);
            check_c("rand_c", 16'(ba + 32), NN);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
